// File: rtl/com_pkg.sv
// Shared definitions for the com frame transmitter: bag codes, framing
// constants, transmitter state encoding and the CRC8 byte step.
package com_pkg;

   // Bag type codes carried in the frame header.
   typedef enum logic [3:0] {
      BAG_ACK   = 4'b0001,
      BAG_NAK   = 4'b0010,
      BAG_STALL = 4'b0011,
      BAG_SETUP = 4'b0100,
      BAG_DATA0 = 4'b1101,
      BAG_DATA1 = 4'b1110
   } bag_t;

   // Framing constants.
   localparam int         PRE_NUM_DEF  = 2;
   localparam logic [7:0] PRE_BYTE     = 8'h55;
   localparam logic [7:0] SYNC_DEF     = 8'hD5;
   localparam logic [7:0] CRC_POLY_DEF = 8'h07;

   // Transmitter FSM states.
   typedef enum logic [3:0] {
      ST_IDLE = 4'd0,
      ST_PRE  = 4'd1,
      ST_SYNC = 4'd2,
      ST_HEAD = 4'd3,
      ST_LENH = 4'd4,
      ST_LENL = 4'd5,
      ST_RD   = 4'd6,
      ST_LD   = 4'd7,
      ST_DATA = 4'd8,
      ST_CRC  = 4'd9,
      ST_DONE = 4'd10
   } tx_state_t;

   // Only data bags carry a payload.
   function automatic logic is_data_bag(input logic [3:0] btype);
      return (btype == BAG_DATA0) || (btype == BAG_DATA1);
   endfunction

   // One CRC8 step over a whole byte, MSB first, no reflection.
   function automatic logic [7:0] crc8_byte(input logic [7:0] crc,
                                            input logic [7:0] din,
                                            input logic [7:0] poly);
      logic [7:0] c;
      c = crc ^ din;
      for (int i = 0; i < 8; i++) begin
         c = c[7] ? ((c << 1) ^ poly) : (c << 1);
      end
      return c;
   endfunction

endpackage

// File: rtl/com_tx_if.sv
// Handshake, RAM read and byte-stream signals of the frame transmitter.
// slave is the transmitter side; master is everything around it.
interface com_tx_if;

   logic        fs_tx;
   logic        fd_tx;
   logic [3:0]  tx_btype;
   logic [11:0] tx_ram_init;
   logic [11:0] tx_ram_rlen;
   logic        ram_en;
   logic [11:0] ram_addr;
   logic [7:0]  ram_data;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic        busy;

   modport master (
      output fs_tx, tx_btype, tx_ram_init, tx_ram_rlen, ram_data, tx_ready,
      input  fd_tx, ram_en, ram_addr, tx_data, tx_valid, busy
   );

   modport slave (
      input  fs_tx, tx_btype, tx_ram_init, tx_ram_rlen, ram_data, tx_ready,
      output fd_tx, ram_en, ram_addr, tx_data, tx_valid, busy
   );

endinterface

// File: rtl/com_crc8.sv
// Running CRC8 over accepted frame bytes; clear wins over update.
module com_crc8
   import com_pkg::*;
#(
   parameter logic [7:0] POLY = CRC_POLY_DEF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       clr,
   input  logic       en,
   input  logic [7:0] din,
   output logic [7:0] crc
);

   logic [7:0] crc_nxt;

   // Next CRC value from clear/update controls.
   always_comb begin
      // NOTE: default assignment first so no path leaves crc_nxt unassigned (no latch).
      crc_nxt = crc;
      if (clr) begin
         crc_nxt = 8'h00;
      end else if (en) begin
         crc_nxt = crc8_byte(crc, din, POLY);
      end
   end

   // CRC register.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments only.
      if (rst) begin
         crc <= 8'h00;
      end else begin
         crc <= crc_nxt;
      end
   end

endmodule

// File: rtl/com_tx.sv
// Frame transmitter: on fs_tx emits preamble, sync, header, length,
// payload fetched from the TX RAM and CRC8 over a valid/ready byte stream.
module com_tx
   import com_pkg::*;
#(
   parameter int         PRE_NUM   = PRE_NUM_DEF,
   parameter logic [7:0] SYNC_BYTE = SYNC_DEF,
   parameter logic [7:0] CRC_POLY  = CRC_POLY_DEF
) (
   input  logic     clk,
   input  logic     rst,
   com_tx_if.slave  bus
);

   localparam logic [3:0] PRE_LAST = 4'(PRE_NUM - 1);

   tx_state_t   state, state_nxt;
   logic [3:0]  btype_q;
   logic [11:0] init_q;
   logic [11:0] len_q;
   logic [11:0] idx_q;
   logic [3:0]  pre_cnt_q;
   logic [7:0]  data_q;
   logic [7:0]  crc;
   logic        start;
   logic        accept;
   logic        crc_en;
   logic        last_byte;

   assign start     = (state == ST_IDLE) && bus.fs_tx;
   assign accept    = bus.tx_valid && bus.tx_ready;
   assign last_byte = (idx_q == len_q - 12'd1);
   assign crc_en    = accept && ((state == ST_HEAD) || (state == ST_LENH) ||
                                 (state == ST_LENL) || (state == ST_DATA));

   com_crc8 #(.POLY(CRC_POLY)) u_crc (
      .clk (clk),
      .rst (rst),
      .clr (start),
      .en  (crc_en),
      .din (bus.tx_data),
      .crc (crc)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic; stream states advance only on an accepted byte.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (bus.fs_tx) state_nxt = ST_PRE;
         ST_PRE:  if (accept && (pre_cnt_q == PRE_LAST)) state_nxt = ST_SYNC;
         ST_SYNC: if (accept) state_nxt = ST_HEAD;
         ST_HEAD: if (accept) state_nxt = ST_LENH;
         ST_LENH: if (accept) state_nxt = ST_LENL;
         ST_LENL: if (accept) state_nxt = (len_q == 12'd0) ? ST_CRC : ST_RD;
         ST_RD:   state_nxt = ST_LD;
         ST_LD:   state_nxt = ST_DATA;
         ST_DATA: if (accept) state_nxt = last_byte ? ST_CRC : ST_RD;
         ST_CRC:  if (accept) state_nxt = ST_DONE;
         ST_DONE: if (!bus.fs_tx) state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Frame fields, preamble counter, payload index and captured RAM byte.
   always_ff @(posedge clk) begin
      // NOTE: frame fields are reset too so ram_addr/tx_data never derive from X.
      if (rst) begin
         btype_q   <= '0;
         init_q    <= '0;
         len_q     <= '0;
         idx_q     <= '0;
         pre_cnt_q <= '0;
         data_q    <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  btype_q   <= bus.tx_btype;
                  init_q    <= bus.tx_ram_init;
                  len_q     <= is_data_bag(bus.tx_btype) ? bus.tx_ram_rlen : 12'd0;
                  idx_q     <= '0;
                  pre_cnt_q <= '0;
               end
            end
            ST_PRE:  if (accept) pre_cnt_q <= pre_cnt_q + 4'd1;
            ST_LD:   data_q <= bus.ram_data;
            // Index stops at len-1, so len = 4095 never wraps it.
            ST_DATA: if (accept && !last_byte) idx_q <= idx_q + 12'd1;
            default: ;
         endcase
      end
   end

   // Moore outputs decoded from the current state.
   always_comb begin
      bus.tx_valid = 1'b0;
      bus.tx_data  = 8'h00;
      bus.ram_en   = 1'b0;
      bus.ram_addr = 12'h000;
      bus.fd_tx    = 1'b0;
      bus.busy     = (state != ST_IDLE);
      case (state)
         ST_PRE:  begin bus.tx_valid = 1'b1; bus.tx_data = PRE_BYTE;              end
         ST_SYNC: begin bus.tx_valid = 1'b1; bus.tx_data = SYNC_BYTE;             end
         ST_HEAD: begin bus.tx_valid = 1'b1; bus.tx_data = {btype_q, ~btype_q};   end
         ST_LENH: begin bus.tx_valid = 1'b1; bus.tx_data = {4'h0, len_q[11:8]};   end
         ST_LENL: begin bus.tx_valid = 1'b1; bus.tx_data = len_q[7:0];            end
         ST_RD:   begin bus.ram_en   = 1'b1; bus.ram_addr = init_q + idx_q;       end
         ST_DATA: begin bus.tx_valid = 1'b1; bus.tx_data = data_q;                end
         ST_CRC:  begin bus.tx_valid = 1'b1; bus.tx_data = crc;                   end
         ST_DONE: bus.fd_tx = 1'b1;
         default: ;
      endcase
   end

endmodule
